// File: rtl/brush_stamper.sv
// Stamps a square brush of radius r around a cursor by issuing one GPU pixel
// write per in-range pixel, spaced at least three cycles apart.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | test current scan pixel; wait for write_available if in range
// ISSUE | GPU write strobe being launched; scan advances
// GAP   | enforced idle cycle between strobes
// DONE  | completion pulse being launched
module brush_stamper #(
    parameter int SCREEN_DIM = 64,
    parameter int MAX_RADIUS = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [5:0] cursor_col,
    input  logic [5:0] cursor_row,
    input  logic [1:0] brush_radius,
    input  logic [7:0] color,
    input  logic       palette_sel,
    input  logic       overlay_sel,
    input  logic       write_available,
    output logic       write,
    output logic [7:0] px_data,
    output logic [5:0] column,
    output logic [5:0] row,
    output logic       image_palette,
    output logic       image_overlay,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, GAP, DONE} state_t;

    localparam logic signed [7:0] DIM8 = 8'(SCREEN_DIM);
    localparam logic [1:0] RMAX = 2'(MAX_RADIUS);

    state_t state_q, state_d;
    logic [5:0] cur_col_q, cur_col_d, cur_row_q, cur_row_d;
    logic [1:0] rad_q, rad_d;
    logic [7:0] color_q, color_d;
    logic pal_q, pal_d, ovl_q, ovl_d;
    logic signed [3:0] dx_q, dx_d, dy_q, dy_d;
    logic last_q, last_d;
    logic write_q, write_d, done_q, done_d, busy_q, busy_d;
    logic [7:0] px_q, px_d;
    logic [5:0] col_q, col_d, row_q, row_d;
    logic img_pal_q, img_pal_d, img_ovl_q, img_ovl_d;

    logic [1:0] rad_in;
    logic signed [3:0] r_in_s, r_s;
    logic signed [7:0] pix_col, pix_row;
    logic in_range, is_last;

    // Radii above MAX_RADIUS are clamped rather than rejected.
    assign rad_in  = (brush_radius > RMAX) ? RMAX : brush_radius;
    assign r_in_s  = $signed({2'b00, rad_in});
    assign r_s     = $signed({2'b00, rad_q});
    assign pix_col = $signed({2'b00, cur_col_q}) + $signed({{4{dx_q[3]}}, dx_q});
    assign pix_row = $signed({2'b00, cur_row_q}) + $signed({{4{dy_q[3]}}, dy_q});
    assign in_range = !pix_col[7] && (pix_col < DIM8) && !pix_row[7] && (pix_row < DIM8);
    assign is_last  = (dx_q == r_s) && (dy_q == r_s);

    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        rad_d     = rad_q;
        color_d   = color_q;
        pal_d     = pal_q;
        ovl_d     = ovl_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        last_d    = last_q;
        px_d      = px_q;
        col_d     = col_q;
        row_d     = row_q;
        img_pal_d = img_pal_q;
        img_ovl_d = img_ovl_q;
        write_d   = (state_q == ISSUE);
        done_d    = (state_q == DONE);
        busy_d    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_col_d = cursor_col;
                    cur_row_d = cursor_row;
                    rad_d     = rad_in;
                    color_d   = color;
                    pal_d     = palette_sel;
                    ovl_d     = overlay_sel;
                    dx_d      = -r_in_s;
                    dy_d      = -r_in_s;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (!in_range) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else if (dx_q == r_s) begin
                        dx_d = -r_s;
                        dy_d = dy_q + 4'sd1;
                    end else begin
                        dx_d = dx_q + 4'sd1;
                    end
                end else if (write_available) begin
                    col_d     = pix_col[5:0];
                    row_d     = pix_row[5:0];
                    px_d      = color_q;
                    img_pal_d = pal_q;
                    img_ovl_d = ovl_q;
                    last_d    = is_last;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Wrap on the final pixel is harmless; GAP exits via last_q.
                if (dx_q == r_s) begin
                    dx_d = -r_s;
                    dy_d = dy_q + 4'sd1;
                end else begin
                    dx_d = dx_q + 4'sd1;
                end
                state_d = GAP;
            end
            GAP:     state_d = last_q ? DONE : CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cur_col_q <= '0;
            cur_row_q <= '0;
            rad_q     <= '0;
            color_q   <= '0;
            pal_q     <= 1'b0;
            ovl_q     <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            last_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            px_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            img_pal_q <= 1'b0;
            img_ovl_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            rad_q     <= rad_d;
            color_q   <= color_d;
            pal_q     <= pal_d;
            ovl_q     <= ovl_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            last_q    <= last_d;
            write_q   <= write_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            px_q      <= px_d;
            col_q     <= col_d;
            row_q     <= row_d;
            img_pal_q <= img_pal_d;
            img_ovl_q <= img_ovl_d;
        end
    end

    assign write         = write_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign px_data       = px_q;
    assign column        = col_q;
    assign row           = row_q;
    assign image_palette = img_pal_q;
    assign image_overlay = img_ovl_q;
endmodule

// File: tb/tb_brush_stamper.sv
// Scoreboard bench for brush_stamper: stimulus pushes expected writes, a
// negedge monitor pops and compares every GPU write strobe.
module tb_brush_stamper;
    logic clk = 1'b0;
    logic rstn, start, palette_sel, overlay_sel, write_available;
    logic [5:0] cursor_col, cursor_row;
    logic [1:0] brush_radius;
    logic [7:0] color;
    logic write, image_palette, image_overlay, busy, done;
    logic [7:0] px_data;
    logic [5:0] column, row;

    brush_stamper dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .brush_radius(brush_radius), .color(color),
        .palette_sel(palette_sel), .overlay_sel(overlay_sel),
        .write_available(write_available), .write(write),
        .px_data(px_data), .column(column), .row(row),
        .image_palette(image_palette), .image_overlay(image_overlay),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] c;
        logic [5:0] r;
        logic [7:0] d;
        logic       p;
        logic       o;
    } px_t;

    px_t sb[$];
    int checks = 0;
    int failures = 0;
    int writes = 0;
    int cyc = 0;
    int last_wr_cyc = -100;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard and keep spacing.
    always @(negedge clk) begin
        if (rstn && write) begin
            px_t got;
            px_t exp;
            writes++;
            chk("strobe_spacing", 32'((cyc - last_wr_cyc) >= 3), 32'd1);
            last_wr_cyc = cyc;
            got = '{c: column, r: row, d: px_data, p: image_palette, o: image_overlay};
            if (sb.size() == 0) begin
                chk("unexpected_write", {10'd0, got}, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                chk("write_pixel", {10'd0, got}, {10'd0, exp});
            end
        end
    end

    task automatic push_stamp(input int cc, input int cr, input int r,
                              input logic [7:0] d, input logic p, input logic o);
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                int c;
                int rr;
                c  = cc + dx;
                rr = cr + dy;
                if (c >= 0 && c < 64 && rr >= 0 && rr < 64)
                    sb.push_back('{c: 6'(c), r: 6'(rr), d: d, p: p, o: o});
            end
        end
    endtask

    task automatic start_stamp(input int cc, input int cr, input int r,
                               input logic [7:0] d, input logic p, input logic o);
        @(negedge clk);
        cursor_col   = 6'(cc);
        cursor_row   = 6'(cr);
        brush_radius = 2'(r);
        color        = d;
        palette_sel  = p;
        overlay_sel  = o;
        start        = 1'b1;
        push_stamp(cc, cr, r, d, p, o);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1 chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        logic saw_write, busy_drop, moved;
        logic [11:0] snap;

        rstn = 1'b0; start = 1'b0; write_available = 1'b1;
        cursor_col = '0; cursor_row = '0; brush_radius = '0; color = '0;
        palette_sel = 1'b0; overlay_sel = 1'b0;
        #12;
        chk("reset_outputs", {8'd0, write, done, busy, image_palette, image_overlay,
                              px_data, column, row, 1'b0}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Single-pixel stamp: cycle-exact timing.
        w0 = writes;
        start_stamp(10, 20, 0, 8'h12, 1'b0, 1'b0);
        chk("t_k_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("t_k1_write", 32'(write), 32'd0);
        chk("t_k1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t_k2_write", 32'(write), 32'd1);
        chk("t_k2_pixel", {12'd0, column, row, px_data}, {12'd0, 6'd10, 6'd20, 8'h12});
        @(posedge clk); #1;
        chk("t_k3_write", 32'(write), 32'd0);
        chk("t_k3_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("t_k4_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("t_k5_busy_done", {30'd0, busy, done}, 32'd0);
        chk("r0_count", 32'(writes - w0), 32'd1);

        // r=1 at (5,5): nine writes in row-major order.
        w0 = writes;
        start_stamp(5, 5, 1, 8'hA5, 1'b1, 1'b0);
        wait_idle();
        chk("r1_count", 32'(writes - w0), 32'd9);

        // Clipped corners.
        w0 = writes;
        start_stamp(0, 0, 3, 8'h3E, 1'b0, 1'b1);
        wait_idle();
        chk("corner00_count", 32'(writes - w0), 32'd16);
        w0 = writes;
        start_stamp(63, 63, 3, 8'hC1, 1'b1, 1'b1);
        wait_idle();
        chk("corner6363_count", 32'(writes - w0), 32'd16);
        w0 = writes;
        start_stamp(62, 1, 2, 8'h0F, 1'b0, 1'b0);
        wait_idle();
        chk("edge_r2_count", 32'(writes - w0), 32'd16);

        // Backpressure mid-stamp.
        w0 = writes;
        start_stamp(30, 30, 1, 8'h3C, 1'b1, 1'b1);
        n = 0;
        while ((writes - w0) < 3 && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        chk("hold_reached", 32'(writes - w0), 32'd3);
        write_available = 1'b0;
        @(posedge clk); #1;
        snap = {column, row};
        saw_write = 1'b0; busy_drop = 1'b0; moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (write) saw_write = 1'b1;
            if (!busy) busy_drop = 1'b1;
            if ({column, row} !== snap) moved = 1'b1;
        end
        chk("hold_no_write", 32'(saw_write), 32'd0);
        chk("hold_busy", 32'(busy_drop), 32'd0);
        chk("hold_stable", 32'(moved), 32'd0);
        chk("hold_count", 32'(writes - w0), 32'd3);
        write_available = 1'b1;
        wait_idle();
        chk("hold_total", 32'(writes - w0), 32'd9);

        // start while busy, with different inputs presented.
        w0 = writes;
        start_stamp(40, 10, 1, 8'h77, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        cursor_col = 6'd20; cursor_row = 6'd20; brush_radius = 2'd3;
        color = 8'hEE; palette_sel = 1'b1; start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        #1 chk("busy_start_count", 32'(writes - w0), 32'd9);

        // Reset during a stamp aborts it.
        start_stamp(20, 20, 2, 8'h55, 1'b1, 1'b0);
        n = 0;
        while (!write && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("abort_reached", 32'(write), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("abort_write", 32'(write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        last_wr_cyc = -100;
        w0 = writes;
        repeat (10) @(posedge clk);
        #1 chk("abort_no_write", 32'(writes - w0), 32'd0);
        start_stamp(7, 8, 0, 8'h99, 1'b0, 1'b0);
        wait_idle();
        chk("after_abort_count", 32'(writes - w0), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/brush_stamper.md
BRUSH_STAMPER -- requirements
Module: brush_stamper

Interface
REQ-001 SHALL have parameter SCREEN_DIM, default 64, meaning pixels per side of the square display (column/row range 0..SCREEN_DIM-1).
REQ-002 SHALL have parameter MAX_RADIUS, default 3, meaning the largest brush radius in pixels.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports named clk and rstn.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rstn, in, 1, async active-low reset.
- start, in, 1, request one stamp.
- cursor_col, in, 6, stamp centre column.
- cursor_row, in, 6, stamp centre row.
- brush_radius, in, 2, radius r (0..MAX_RADIUS).
- color, in, 8, pixel data to write.
- palette_sel, in, 1, target image palette flag.
- overlay_sel, in, 1, target overlay flag.
- write_available, in, 1, GPU ready to accept a write.
- write, out, 1, one-cycle GPU write strobe.
- px_data, out, 8, pixel data to GPU.
- column, out, 6, GPU column.
- row, out, 6, GPU row.
- image_palette, out, 1, GPU palette flag.
- image_overlay, out, 1, GPU overlay flag.
- busy, out, 1, stamp in progress.
- done, out, 1, one-cycle completion pulse.

Function
REQ-005 SHALL implement FSM states IDLE, CHECK, ISSUE, GAP, DONE; all outputs registered.
REQ-006 IDLE: start=1 at a rising edge latches cursor_col, cursor_row, brush_radius, color, palette_sel, overlay_sel; sets dy=dx=-r; next state CHECK. start=0: stay IDLE.
REQ-007 start SHALL be ignored in every state other than IDLE; latched values SHALL NOT change mid-stamp.
REQ-008 Pixel coordinates SHALL be computed as col=cursor_col+dx, row=cursor_row+dy in signed 8-bit arithmetic; a pixel is in range when 0<=col<SCREEN_DIM and 0<=row<SCREEN_DIM.
REQ-009 Scan order SHALL be row-major: dx from -r to +r inner, dy from -r to +r outer; (2r+1)^2 candidate pixels.
REQ-010 CHECK, pixel out of range: advance scan, no write; if it was the last pixel, go DONE, else stay CHECK.
REQ-011 CHECK, pixel in range and write_available=0: hold state and counters, no write.
REQ-012 CHECK, pixel in range and write_available=1: load column/row with that pixel and px_data/image_palette/image_overlay with the latched values; go ISSUE.
REQ-013 ISSUE: write=1 for exactly one cycle; advance scan; go GAP.
REQ-014 GAP: write=0 for one cycle regardless of write_available; go DONE if the issued pixel was last, else CHECK.
REQ-015 DONE: done=1 for one cycle; go IDLE.
REQ-016 busy SHALL be 1 in CHECK, ISSUE, GAP, DONE and 0 in IDLE.
REQ-017 Minimum spacing between write strobes SHALL be 3 cycles; each in-range pixel SHALL be written exactly once; out-of-range pixels SHALL never produce a write.
REQ-018 column, row, px_data, image_palette and image_overlay SHALL hold their last values outside ISSUE.

Reset
REQ-019 rstn=0 SHALL asynchronously force state IDLE, write=0, done=0, busy=0, px_data=0, column=0, row=0, image_palette=0, image_overlay=0, scan counters 0.
REQ-020 Reset during any state SHALL abort the stamp; no write SHALL occur until a new start after rstn returns to 1.

Verification
REQ-021 r=0, cursor (10,20), color 0x12, write_available=1, start sampled at edge k -> write=1 in cycle k+2 with column=10, row=20, px_data=0x12; done=1 in cycle k+4; busy=0 from k+5.
REQ-022 r=1, cursor (5,5), write_available=1 -> 9 writes, order (4,4),(5,4),(6,4),(4,5)...(6,6) as (column,row), strobes 3 cycles apart.
REQ-023 r=3, cursor (0,0) -> exactly 16 writes covering column,row 0..3; repeat at (63,63) -> 16 writes covering 60..63; no out-of-range write.
REQ-024 write_available held 0 for 50 cycles mid-stamp -> no write, busy=1, outputs stable; on release, stamp resumes at the held pixel with no skip or duplicate.
REQ-025 start pulsed while busy -> ignored; total writes equal the first stamp only.
REQ-026 rstn asserted in ISSUE of a r=2 stamp -> write=0 immediately (same cycle), busy=0; after release and a new r=0 start -> exactly one write.
